mat_mul_ctrl: RTL and testbench

- Sequencer for the matrix-multiply datapath: walks every result coefficient C[i][j] of an N×N product.
- Issues operand-memory reads (row i of A, column j of B) and drives the adder tree's write-enable and state inputs.
- Tracks results in flight, pairs each returning coefficient with its (i,j) address, and writes it to the result sink.
- Sits between the top-level start/done interface and the operand memories, multiplier bank, Sum_Block adder tree and result memory.

---
 rtl/mat_mul_ctrl_if.sv | 32 +++
 rtl/mat_mul_ctrl.sv | 166 ++++++++++++++++
 tb/tb_mat_mul_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mat_mul_ctrl_if.sv
// Bus between mat_mul_ctrl and its surroundings: the start/done control pair,
// the operand-read strobe and indices, the Sum_Block handshake and the result
// write port. The controller uses the master modport; the environment uses slave.
interface mat_mul_ctrl_if #(
  parameter int IDX_W = 4
);
  logic               start;
  logic               busy;
  logic               done;
  logic               err_unexp;
  logic               res_ready;
  logic               a_rd_en;
  logic [IDX_W-1:0]   a_row;
  logic [IDX_W-1:0]   b_col;
  logic               sum_we;
  logic               sum_state;
  logic               sum_done;
  logic               res_we;
  logic [2*IDX_W-1:0] res_addr;

  modport master (
    input  start, res_ready, sum_done,
    output busy, done, err_unexp, a_rd_en, a_row, b_col,
           sum_we, sum_state, res_we, res_addr
  );

  modport slave (
    output start, res_ready, sum_done,
    input  busy, done, err_unexp, a_rd_en, a_row, b_col,
           sum_we, sum_state, res_we, res_addr
  );
endinterface

// File: rtl/mat_mul_ctrl.sv
// mat_mul_ctrl: sequencer for an N x N matrix multiply. Walks every C[i][j],
// issues operand reads, delays the issue strobe into the Sum_Block write enable,
// and pairs each returning coefficient with its (i,j) through an address FIFO.
// Optional build macro MAT_CTRL_PERF_EN adds perf_busy / perf_stall counters.
module mat_mul_ctrl #(
  parameter int DIM          = 16,
  parameter int IDX_W        = 4,
  parameter int ISSUE_LAT    = 2,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic              src_clk,
  input  logic              rst_n,
  mat_mul_ctrl_if.master    bus
`ifdef MAT_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_busy,
  output logic [31:0]       perf_stall
`endif
);

  localparam int PTR_W  = $clog2(MAX_INFLIGHT);
  localparam int CNT_W  = PTR_W + 1;
  localparam int ADDR_W = 2 * IDX_W;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [IDX_W-1:0] i;
    logic [IDX_W-1:0] j;
  } coord_t;

  state_t           state;
  logic [IDX_W-1:0] row_idx;
  logic [IDX_W-1:0] col_idx;
  logic [CNT_W-1:0] inflight;
  coord_t           fifo_mem [MAX_INFLIGHT];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             err_q;

  logic             issue_ok;
  logic             issue;
  logic             last_issue;
  logic             fifo_empty;
  logic             ret_valid;
  coord_t           head;

  // Issue gating, FIFO status and the head entry of the return path.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    issue_ok   = 1'b0;
    issue      = 1'b0;
    last_issue = 1'b0;
    issue_ok   = bus.res_ready && (inflight < CNT_W'(MAX_INFLIGHT));
    issue      = (state == ISSUE) && issue_ok;
    last_issue = issue && (row_idx == IDX_W'(DIM - 1)) && (col_idx == IDX_W'(DIM - 1));
    fifo_empty = (wr_ptr == rd_ptr);
    ret_valid  = bus.sum_done && !fifo_empty;
    head       = fifo_mem[rd_ptr[PTR_W-1:0]];
  end

  // Job FSM and the (i,j) walk; i advances when j wraps.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      row_idx <= '0;
      col_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            row_idx <= '0;
            col_idx <= '0;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (issue) begin
            if (col_idx == IDX_W'(DIM - 1)) begin
              col_idx <= '0;
              row_idx <= (row_idx == IDX_W'(DIM - 1)) ? '0 : row_idx + 1'b1;
            end else begin
              col_idx <= col_idx + 1'b1;
            end
            if (last_issue) state <= DRAIN;
          end
        end
        DRAIN:   if (inflight == '0) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // In-flight count, address FIFO and the sticky unexpected-return flag.
  // NOTE: the FIFO storage is reset along with its pointers; it is only a few
  // entries, and it keeps the head (and so res_addr) deterministic from reset.
  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      err_q    <= 1'b0;
      for (int k = 0; k < MAX_INFLIGHT; k++) fifo_mem[k] <= '0;
    end else begin
      case ({issue, ret_valid})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
      if (issue) begin
        fifo_mem[wr_ptr[PTR_W-1:0]] <= '{i: row_idx, j: col_idx};
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (ret_valid) rd_ptr <= rd_ptr + 1'b1;
      if (bus.sum_done && fifo_empty) err_q <= 1'b1;
    end
  end

  // sum_we is the issue strobe delayed to line up with the operand products.
  generate
    if (ISSUE_LAT == 0) begin : g_we_comb
      assign bus.sum_we = issue;
    end else begin : g_we_pipe
      logic [ISSUE_LAT-1:0] we_pipe;
      // Shift the issue strobe through ISSUE_LAT stages.
      always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n) we_pipe <= '0;
        else        we_pipe <= ISSUE_LAT'({we_pipe, issue});
      end
      assign bus.sum_we = we_pipe[ISSUE_LAT-1];
    end
  endgenerate

  assign bus.a_rd_en   = issue;
  assign bus.a_row     = row_idx;
  assign bus.b_col     = col_idx;
  assign bus.busy      = (state == ISSUE) || (state == DRAIN);
  assign bus.sum_state = (state == ISSUE) || (state == DRAIN);
  assign bus.done      = (state == DONE);
  assign bus.res_we    = ret_valid;
  assign bus.res_addr  = ret_valid ? ADDR_W'(head.i) * ADDR_W'(DIM) + ADDR_W'(head.j) : '0;
  assign bus.err_unexp = err_q;

`ifdef MAT_CTRL_PERF_EN
  // Saturating activity counters, cleared when a job is accepted.
  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_busy  <= '0;
      perf_stall <= '0;
    end else if (state == IDLE && bus.start) begin
      perf_busy  <= '0;
      perf_stall <= '0;
    end else begin
      if ((state == ISSUE || state == DRAIN) && perf_busy != '1)
        perf_busy <= perf_busy + 1'b1;
      if (state == ISSUE && !issue_ok && perf_stall != '1)
        perf_stall <= perf_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mat_mul_ctrl.sv
// Directed testbench for mat_mul_ctrl (DIM=4). A small Sum_Block model turns
// sum_we into sum_done after a configurable latency; a negedge monitor logs
// issues, result writes and the done pulse for the main sequence to compare.
module tb_mat_mul_ctrl;
  localparam int DIM          = 4;
  localparam int IDX_W        = 2;
  localparam int ISSUE_LAT    = 2;
  localparam int MAX_INFLIGHT = 8;

  logic src_clk = 1'b0;
  logic rst_n   = 1'b0;
  always #5 src_clk = ~src_clk;

  mat_mul_ctrl_if #(.IDX_W(IDX_W)) bus ();

`ifdef MAT_CTRL_PERF_EN
  logic [31:0] perf_busy;
  logic [31:0] perf_stall;
`endif

  mat_mul_ctrl #(
    .DIM(DIM), .IDX_W(IDX_W), .ISSUE_LAT(ISSUE_LAT), .MAX_INFLIGHT(MAX_INFLIGHT)
  ) dut (
    .src_clk (src_clk),
    .rst_n   (rst_n),
    .bus     (bus)
`ifdef MAT_CTRL_PERF_EN
    ,
    .perf_busy  (perf_busy),
    .perf_stall (perf_stall)
`endif
  );

  // Sum_Block model: sum_done = sum_we delayed by lat cycles, plus injected pulses.
  int          lat = 4;
  logic        inj = 1'b0;
  logic [15:0] sum_pipe;
  always @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) sum_pipe <= '0;
    else        sum_pipe <= {sum_pipe[14:0], bus.sum_we};
  end
  assign bus.sum_done = sum_pipe[lat-1] | inj;

  int cyc = 0;
  always @(posedge src_clk) cyc <= cyc + 1;

  // Monitor, sampling on the falling edge.
  int                   t0 = 0;
  logic [2*IDX_W-1:0]   iss_q[$];
  logic [2*IDX_W-1:0]   res_q[$];
  int                   done_cnt = 0;
  int                   done_cyc = -1;
  int                   tb_infl  = 0;
  int                   max_infl = 0;
  logic [63:0]          rd_hist  = '0;
  always @(negedge src_clk) begin
    if (!rst_n) begin
      tb_infl = 0;
    end else begin
      if (bus.a_rd_en) iss_q.push_back({bus.a_row, bus.b_col});
      if (bus.res_we)  res_q.push_back(bus.res_addr);
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc - t0;
      end
      tb_infl = tb_infl + int'(bus.a_rd_en) - int'(bus.res_we);
      if (tb_infl > max_infl) max_infl = tb_infl;
    end
    if (cyc - t0 >= 0 && cyc - t0 < 64) rd_hist[cyc - t0] = bus.a_rd_en;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full job: res_ready low for ISSUE cycles lo..hi, extra start pulses at
  // cycles sa/sb, then compare issue order, result order, done timing.
  task automatic run_job(input int latency, input int lo, input int hi,
                         input int sa, input int sb, input int exp_done,
                         input int exp_stall, input string tag);
    int ib, rb, db;
    lat = latency;
    ib  = iss_q.size();
    rb  = res_q.size();
    db  = done_cnt;
    @(posedge src_clk); #1;
    t0 = cyc;
    bus.start = 1'b1;
    for (int k = 1; k <= exp_done + 10; k++) begin
      @(posedge src_clk); #1;
      bus.start     = (k == sa) || (k == sb);
      bus.res_ready = !(k >= lo && k <= hi);
    end
    bus.res_ready = 1'b1;
    check({tag, "_done_cnt"}, done_cnt - db, 1);
    check({tag, "_done_cyc"}, done_cyc, exp_done);
    check({tag, "_iss_cnt"},  iss_q.size() - ib, 16);
    check({tag, "_res_cnt"},  res_q.size() - rb, 16);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("%s_iss%0d", tag, k), 32'(iss_q[ib + k]), k);
      check($sformatf("%s_res%0d", tag, k), 32'(res_q[rb + k]), k);
    end
    check({tag, "_busy_after"}, bus.busy, 0);
`ifdef MAT_CTRL_PERF_EN
    check({tag, "_perf_busy"},  perf_busy,  exp_done - 1);
    check({tag, "_perf_stall"}, perf_stall, exp_stall);
`else
    if (exp_stall < 0) check({tag, "_stall_arg"}, exp_stall, 0);
`endif
  endtask

  initial begin
    int db;
    bus.start     = 1'b0;
    bus.res_ready = 1'b1;

    // Reset state.
    repeat (3) @(posedge src_clk);
    #1;
    check("rst_a_rd_en",  bus.a_rd_en,   0);
    check("rst_busy",     bus.busy,      0);
    check("rst_done",     bus.done,      0);
    check("rst_sum_we",   bus.sum_we,    0);
    check("rst_sum_st",   bus.sum_state, 0);
    check("rst_res_we",   bus.res_we,    0);
    check("rst_res_addr", bus.res_addr,  0);
    check("rst_err",      bus.err_unexp, 0);
    check("rst_rows",     {bus.a_row, bus.b_col}, 0);
    rst_n = 1'b1;
    @(posedge src_clk); #1;
    check("idle_busy", bus.busy, 0);

    // Plain job: 16 issues, done at 16+2+4+2.
    run_job(4, 0, -1, 0, 0, 24, 0, "basic");

    // res_ready low for ISSUE cycles 5..9: five stall cycles, done shifts by 5.
    run_job(4, 5, 9, 0, 0, 29, 5, "stall");
    check("stall_rd_window", 32'(rd_hist[10:4]), 32'b1000001);

    // Long Sum_Block latency: in-flight limit of 8 is reached but never passed.
    run_job(12, 0, -1, 0, 0, 39, 7, "lat12");
    check("lat12_max_inflight", max_infl, MAX_INFLIGHT);
    lat = 4;

    // start pulses while busy (ISSUE and DRAIN) are ignored.
    run_job(4, 0, -1, 5, 20, 24, 0, "startbusy");

    // Unexpected sum_done in IDLE: no write, sticky error.
    db = res_q.size();
    @(posedge src_clk); #1;
    inj = 1'b1;
    @(negedge src_clk);
    check("unexp_res_we", bus.res_we, 0);
    @(posedge src_clk); #1;
    inj = 1'b0;
    check("unexp_err", bus.err_unexp, 1);
    check("unexp_no_write", res_q.size() - db, 0);
    run_job(4, 0, -1, 0, 0, 24, 0, "after_err");
    check("err_held", bus.err_unexp, 1);

    // Reset during the 7th issue aborts the job with no done pulse.
    db = done_cnt;
    @(posedge src_clk); #1;
    t0 = cyc;
    bus.start = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge src_clk); #1;
      bus.start = 1'b0;
    end
    check("abort_issuing", bus.a_rd_en, 1);
    rst_n = 1'b0;
    #1;
    check("abort_rd_en", bus.a_rd_en,   0);
    check("abort_busy",  bus.busy,      0);
    check("abort_err",   bus.err_unexp, 0);
    repeat (3) @(posedge src_clk);
    #1;
    rst_n = 1'b1;
    repeat (30) @(posedge src_clk);
    #1;
    check("abort_no_done", done_cnt - db, 0);
    check("abort_idle",    bus.busy, 0);
    run_job(4, 0, -1, 0, 0, 24, 0, "post_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
